// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I memory-access constants, funct3 encodings and load/store FSM states
package rv32i_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } mem_state_t;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - load lane select with sign/zero extension
//
// Ports:
//   funct3   in  3   load size/sign (LB, LH, LW, LBU, LHU)
//   addr_lo  in  2   low byte-address bits of the load
//   word     in  32  raw aligned bus word
//   result   out 32  extended load value
module load_extend
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[{addr_lo, 3'b000} +: 8];
        // Halfwords only look at addr[1]; addr[0] is either trapped upstream or ignored.
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   result = {24'b0, byte_lane};
            F3_H:    result = {{16{half_lane[15]}}, half_lane};
            F3_HU:   result = {16'b0, half_lane};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32I load/store stage with single-outstanding bus handshake
//
// Optional feature macro: MISALIGN_TRAP_EN (adds the misaligned output and the
// IDLE->DONE trap path; when undefined, low address bits are simply ignored).
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   opcode, funct3              decoded instruction fields
//   read_address, write_address ALU load / store addresses
//   store_data                  store operand
//   bus_rdata, bus_busy         bus response
//   bus_read, bus_write         one-cycle request strobes
//   bus_addr, bus_wdata, bus_sel word-aligned request, held through WAIT
//   stall                       holds PC and register file while busy
//   load_data, load_valid       extended load result and its write enable
//   bus_error                   one-cycle timeout pulse
//   misaligned                  one-cycle misalignment trap (MISALIGN_TRAP_EN only)
module mem_access_unit
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] read_address,
    input  logic [31:0] write_address,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_error
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_t  state, state_d;
    logic [CW-1:0] cnt;

    logic        legal_load, legal_store, mem_op, trap;
    logic [31:0] addr_in, wdata_in;
    logic [3:0]  sel_in;

    logic [31:0] addr_q, wdata_q;
    logic [3:0]  sel_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic        load_q, err_q, mis_q;
    logic [31:0] ext_result;

    assign legal_load  = (opcode == OPC_LOAD)  && (funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign legal_store = (opcode == OPC_STORE) && (funct3 inside {F3_B, F3_H, F3_W});
    assign mem_op      = legal_load || legal_store;
    assign addr_in     = legal_load ? read_address : write_address;

    // funct3[1:0] encodes size for both signed and unsigned loads: 00 byte, 01 half, 10 word.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                sel_in   = 4'b0001 << addr_in[1:0];
                wdata_in = {4{store_data[7:0]}};
            end
            2'b01: begin
                sel_in   = addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{store_data[15:0]}};
            end
            default: begin
                sel_in   = 4'b1111;
                wdata_in = store_data;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign trap = ((funct3[1:0] == 2'b01) && addr_in[0]) ||
                  ((funct3[1:0] == 2'b10) && (addr_in[1:0] != 2'b00));
    assign misaligned = (state == DONE) && mis_q;
`else
    assign trap = 1'b0;
`endif

    load_extend u_load_extend (
        .funct3  (f3_q),
        .addr_lo (lo_q),
        .word    (bus_rdata),
        .result  (ext_result)
    );

    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_sel   = sel_q;

    always_comb begin
        state_d    = state;
        stall      = 1'b0;
        bus_read   = 1'b0;
        bus_write  = 1'b0;
        load_valid = 1'b0;
        bus_error  = 1'b0;
        case (state)
            IDLE: begin
                // Combinational so the PC never steps past the memory instruction.
                if (mem_op) begin
                    stall   = 1'b1;
                    state_d = trap ? DONE : REQ;
                end
            end
            REQ: begin
                stall     = 1'b1;
                bus_read  = load_q;
                bus_write = !load_q;
                state_d   = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                // A response in the same cycle as the timeout still wins.
                if (!bus_busy || (cnt == CW'(TIMEOUT_CYCLES))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                load_valid = load_q && !err_q && !mis_q;
                bus_error  = err_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
            f3_q      <= '0;
            lo_q      <= '0;
            load_q    <= 1'b0;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
            load_data <= '0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        addr_q  <= {addr_in[31:2], 2'b00};
                        wdata_q <= wdata_in;
                        sel_q   <= sel_in;
                        f3_q    <= funct3;
                        lo_q    <= addr_in[1:0];
                        load_q  <= legal_load;
                        err_q   <= 1'b0;
                        mis_q   <= trap;
                    end
                end
                REQ: cnt <= '0;
                WAIT: begin
                    if (!bus_busy) begin
                        if (load_q) begin
                            load_data <= ext_result;
                        end
                    end else if (cnt == CW'(TIMEOUT_CYCLES)) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] read_address, write_address, store_data, bus_rdata;
    logic        bus_busy;

    logic        d_rd, d_wr, d_stall, d_lv, d_err, d_mis;
    logic [31:0] d_addr, d_wdata, d_ld;
    logic [3:0]  d_sel;
    logic        t_rd, t_wr, t_stall, t_lv, t_err, t_mis;
    logic [31:0] t_addr, t_wdata, t_ld;
    logic [3:0]  t_sel;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .read_address(read_address), .write_address(write_address),
        .store_data(store_data), .bus_rdata(bus_rdata), .bus_busy(bus_busy),
        .bus_read(d_rd), .bus_write(d_wr), .bus_addr(d_addr), .bus_wdata(d_wdata),
        .bus_sel(d_sel), .stall(d_stall), .load_data(d_ld), .load_valid(d_lv),
        .bus_error(d_err)
`ifdef MISALIGN_TRAP_EN
        , .misaligned(d_mis)
`endif
    );

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
        .read_address(read_address), .write_address(write_address),
        .store_data(store_data), .bus_rdata(bus_rdata), .bus_busy(bus_busy),
        .bus_read(t_rd), .bus_write(t_wr), .bus_addr(t_addr), .bus_wdata(t_wdata),
        .bus_sel(t_sel), .stall(t_stall), .load_data(t_ld), .load_valid(t_lv),
        .bus_error(t_err)
`ifdef MISALIGN_TRAP_EN
        , .misaligned(t_mis)
`endif
    );

`ifndef MISALIGN_TRAP_EN
    assign d_mis = 1'b0;
    assign t_mis = 1'b0;
`endif

    int nchecks = 0;
    int nerrors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Which instance the per-cycle compare looks at.
    logic use_to = 1'b0;
    logic        c_rd, c_wr, c_stall, c_lv, c_err, c_mis;
    logic [31:0] c_addr, c_wdata, c_ld;
    logic [3:0]  c_sel;
    assign c_rd    = use_to ? t_rd    : d_rd;
    assign c_wr    = use_to ? t_wr    : d_wr;
    assign c_stall = use_to ? t_stall : d_stall;
    assign c_lv    = use_to ? t_lv    : d_lv;
    assign c_err   = use_to ? t_err   : d_err;
    assign c_mis   = use_to ? t_mis   : d_mis;
    assign c_addr  = use_to ? t_addr  : d_addr;
    assign c_wdata = use_to ? t_wdata : d_wdata;
    assign c_ld    = use_to ? t_ld    : d_ld;
    assign c_sel   = use_to ? t_sel   : d_sel;

    // Expected outputs for the current cycle, filled in by the model.
    logic        chk_en = 1'b0, exp_first = 1'b0, chk_bus = 1'b0, exp_store = 1'b0;
    logic        exp_stall, exp_rd, exp_wr, exp_lv, exp_err, exp_mis;
    logic [31:0] exp_addr, exp_wdata, exp_ld;
    logic [3:0]  exp_sel;

    int          stall_cnt, err_pulses;
    logic [31:0] snap_addr, snap_wdata, snap_ld;
    logic [3:0]  snap_sel;

    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_first) begin
                stall_cnt  = 0;
                err_pulses = 0;
            end
            check("stall",      32'(c_stall), 32'(exp_stall));
            check("bus_read",   32'(c_rd),    32'(exp_rd));
            check("bus_write",  32'(c_wr),    32'(exp_wr));
            check("load_valid", 32'(c_lv),    32'(exp_lv));
            check("bus_error",  32'(c_err),   32'(exp_err));
            check("misaligned", 32'(c_mis),   32'(exp_mis));
            if (chk_bus) begin
                check("bus_addr", c_addr, exp_addr);
                check("bus_sel",  32'(c_sel), 32'(exp_sel));
                if (exp_store) check("bus_wdata", c_wdata, exp_wdata);
                snap_addr  = c_addr;
                snap_sel   = c_sel;
                snap_wdata = c_wdata;
            end
            if (exp_lv) begin
                check("load_data", c_ld, exp_ld);
                snap_ld = c_ld;
            end
            if (c_stall) stall_cnt++;
            if (c_err)   err_pulses++;
        end
    end

    function automatic int acc_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic int lane_of(input int size, input logic [31:0] a);
        if (size == 4) return 0;
        if (size == 2) return a[1] ? 2 : 0;
        return int'(a[1:0]);
    endfunction

    function automatic logic [3:0] m_sel(input int size, input logic [31:0] a);
        logic [3:0] base;
        base = (size == 4) ? 4'b1111 : (size == 2) ? 4'b0011 : 4'b0001;
        return base << lane_of(size, a);
    endfunction

    function automatic logic [31:0] m_wdata(input int size, input logic [31:0] d);
        if (size == 1) return {4{d[7:0]}};
        if (size == 2) return {2{d[15:0]}};
        return d;
    endfunction

    function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int size;
        logic [31:0] sh;
        size = acc_size(f3);
        sh = rd >> (8 * lane_of(size, a));
        if (size == 4) return rd;
        if (size == 2) return f3[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        return f3[2] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
    endfunction

    // One instruction presented from IDLE until the DUT has finished with it.
    // The opcode is held through DONE, where it must be ignored.
    task automatic run_access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sd, input logic [31:0] rd, input int nb,
                              input int tmo, input logic sel_to);
        logic is_ld, is_st, legal, err, mis;
        int size, done_k;
        is_ld = (op == 7'b0000011) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        is_st = (op == 7'b0100011) && (f3 inside {3'd0, 3'd1, 3'd2});
        legal = is_ld || is_st;
        size  = acc_size(f3);
`ifdef MISALIGN_TRAP_EN
        mis = legal && (((size == 2) && addr[0]) || ((size == 4) && (addr[1:0] != 2'b00)));
`else
        mis = 1'b0;
`endif
        err = legal && !mis && (nb > tmo);
        done_k = !legal ? 0 : mis ? 1 : 2 + (err ? tmo + 1 : nb + 1);
        use_to    = sel_to;
        exp_addr  = {addr[31:2], 2'b00};
        exp_sel   = m_sel(size, addr);
        exp_wdata = m_wdata(size, sd);
        exp_ld    = m_ext(f3, addr, rd);
        exp_store = is_st;
        for (int k = 0; k <= done_k; k++) begin
            opcode        = op;
            funct3        = f3;
            read_address  = is_st ? ~addr : addr;
            write_address = is_st ? addr : ~addr;
            store_data    = sd;
            bus_busy      = (k == 1) || (k >= 2 && (k - 2) < nb);
            bus_rdata     = bus_busy ? ~rd : rd;
            exp_first = (k == 0);
            exp_stall = legal && (k < done_k);
            exp_rd    = is_ld && !mis && (k == 1);
            exp_wr    = is_st && !mis && (k == 1);
            exp_lv    = is_ld && !mis && !err && (k == done_k);
            exp_err   = err && (k == done_k);
            exp_mis   = mis && (k == done_k);
            chk_bus   = legal && !mis && (k >= 1) && (k < done_k);
            chk_en    = 1'b1;
            @(posedge clk);
            #1;
        end
        chk_en   = 1'b0;
        bus_busy = 1'b0;
    endtask

    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, ADD = 7'b0110011;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; opcode = ADD; funct3 = 3'd0; read_address = '0; write_address = '0;
        store_data = '0; bus_rdata = '0; bus_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall",  32'(d_stall), 32'd0);
        check("rst_read",   32'(d_rd),    32'd0);
        check("rst_write",  32'(d_wr),    32'd0);
        check("rst_addr",   d_addr,       32'd0);
        check("rst_ldata",  d_ld,         32'd0);
        check("rst_lvalid", 32'(d_lv),    32'd0);
        check("rst_err",    32'(d_err),   32'd0);
        @(posedge clk); #1;

        run_access(ST, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 0, 255, 1'b0);
        check("sw_addr",   snap_addr,      32'h1000_0004);
        check("sw_sel",    32'(snap_sel),  32'hF);
        check("sw_wdata",  snap_wdata,     32'hDEAD_BEEF);
        check("sw_stalls", 32'(stall_cnt), 32'd3);

        run_access(LD, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 0, 255, 1'b0);
        check("lb_sel",  32'(snap_sel), 32'h8);
        check("lb_data", snap_ld,       32'hFFFF_FF80);
        run_access(LD, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 0, 255, 1'b0);
        check("lbu_data", snap_ld, 32'h0000_0080);

        run_access(ST, 3'b001, 32'h0000_0002, 32'h0000_1234, 32'h0, 5, 255, 1'b0);
        check("sh_wdata",  snap_wdata,     32'h1234_1234);
        check("sh_sel",    32'(snap_sel),  32'hC);
        check("sh_stalls", 32'(stall_cnt), 32'd8);

        run_access(LD, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF_7F01, 1, 255, 1'b0);
        check("lh_data", snap_ld, 32'hFFFF_80FF);
        run_access(LD, 3'b101, 32'h0000_0100, 32'h0, 32'h80FF_7F01, 0, 255, 1'b0);
        check("lhu_data", snap_ld, 32'h0000_7F01);
        run_access(ST, 3'b000, 32'h0000_0001, 32'h0000_00AB, 32'h0, 0, 255, 1'b0);
        check("sb_wdata", snap_wdata,    32'hABAB_ABAB);
        check("sb_sel",   32'(snap_sel), 32'h2);
        run_access(LD, 3'b010, 32'h0000_0201, 32'h0, 32'h1357_9BDF, 2, 255, 1'b0);
        run_access(LD, 3'b001, 32'h0000_0003, 32'h0, 32'h8001_7FFF, 2, 255, 1'b0);
        run_access(LD, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0, 255, 1'b0);
        run_access(ST, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 0, 255, 1'b0);
        run_access(ADD, 3'b000, 32'h0000_0000, 32'h0, 32'h0, 0, 255, 1'b0);
        run_access(ST, 3'b010, 32'h0000_0010, 32'h0102_0304, 32'h0, 255, 255, 1'b0);

        // Reset while WAIT is stuck on a busy bus.
        opcode = LD; funct3 = 3'b010; read_address = 32'h40; write_address = 32'h0;
        bus_busy = 1'b0;
        @(posedge clk); #1 bus_busy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_stall", 32'(d_stall), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; opcode = ADD; bus_busy = 1'b0;
        @(negedge clk);
        check("midrst_stall",  32'(d_stall), 32'd0);
        check("midrst_read",   32'(d_rd),    32'd0);
        check("midrst_addr",   d_addr,       32'd0);
        check("midrst_ldata",  d_ld,         32'd0);
        check("midrst_lvalid", 32'(d_lv),    32'd0);
        check("midrst_err",    32'(d_err),   32'd0);
        @(posedge clk); #1;

        run_access(LD, 3'b010, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 20, 4, 1'b1);
        check("to_err_pulses", 32'(err_pulses), 32'd1);
        run_access(LD, 3'b010, 32'h0000_0024, 32'h0, 32'h0BAD_CAFE, 4, 4, 1'b1);
        check("to_recover_ld", snap_ld, 32'h0BAD_CAFE);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store stage directly downstream of the ALU in the RV32I core. It consumes the ALU's `read_address`/`write_address`, the decoded opcode/funct3, and the store operand. It runs a single-outstanding-request handshake on the data bus and returns sign/zero-extended load data to the register file. While an access is in flight it stalls the PC and register-file write path.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in WAIT before the access is aborted.

Ports:
- `clk`  in  1  core clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  7  instruction opcode; load = 7'b0000011, store = 7'b0100011.
- `funct3`  in  3  access size/sign.
- `read_address`  in  32  ALU load address.
- `write_address`  in  32  ALU store address.
- `store_data`  in  32  reg2 value for stores.
- `bus_rdata`  in  32  bus read data; valid in the cycle `bus_busy` is low during WAIT.
- `bus_busy`  in  1  bus still servicing the request.
- `bus_read`  out  1  one-cycle read strobe.
- `bus_write`  out  1  one-cycle write strobe.
- `bus_addr`  out  32  word-aligned address {addr[31:2],2'b00}.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_sel`  out  4  byte enables.
- `stall`  out  1  hold PC and regfile.
- `load_data`  out  32  extended load result.
- `load_valid`  out  1  regfile write enable for `load_data`.
- `bus_error`  out  1  one-cycle pulse on timeout.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE:**
  - A load/store opcode with legal funct3 registers the address, data, sel and direction, then moves to REQ.
  - Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal store funct3: 000 SB, 001 SH, 010 SW.
  - Any other opcode/funct3: no action, no stall.
- **REQ:** `bus_read` or `bus_write` high for exactly one cycle; go to WAIT.
- **WAIT:**
  - `bus_addr`, `bus_wdata` and `bus_sel` are held stable.
  - When `bus_busy`=0: capture `bus_rdata` (loads) and go to DONE.
  - When the timeout counter reaches `TIMEOUT_CYCLES`: go to DONE with error.
- **DONE:**
  - `stall`=0.
  - `load_valid`=1 for loads without error.
  - `bus_error`=1 if timed out.
  - Next state is always IDLE.
- **Byte enables:**
  - SB/LB: `bus_sel`=4'b0001<<addr[1:0].
  - SH/LH: 4'b0011 if addr[1]=0, else 4'b1100.
  - Word: 4'b1111.
- **Store data:** SB replicates byte ×4; SH replicates half ×2.
- **Load extension:** select the lane by addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU).

## Timing
- `stall` = (IDLE & legal mem op) | REQ | WAIT.
  - Combinational from `opcode`/`funct3` in IDLE, so the PC never advances past the memory instruction.
- Minimum access latency is 4 cycles: IDLE (cycle 0), REQ (1), WAIT with busy=0 (2), DONE (3).
  - The PC advances at the end of cycle 3.
  - Each extra busy cycle adds one.
- The timeout counter clears on entry to WAIT and increments each busy cycle.
- Reset values: state=IDLE, counter=0, and all outputs 0 (including `stall`, strobes, `bus_addr`, `load_data`).
- Reset mid-access: return to IDLE on the next edge and abandon the bus transaction; no `load_valid` or `bus_error`.
- A new mem instruction present during DONE is ignored; it is accepted from IDLE on the following cycle.
- A `bus_busy` change during REQ is ignored; it is sampled only in WAIT.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Such an access skips REQ/WAIT: IDLE→DONE with `misaligned` (extra 1-bit output) pulsed, no bus strobe, `load_valid`=0.
  - Latency is 2 cycles.
- Undefined:
  - No `misaligned` port.
  - The offending low address bits are ignored: a halfword uses addr[1] only, a word is forced aligned.
  - The access proceeds normally.

## Structure
- `rv32i_pkg` holds:
  - opcode constants (OPC_LOAD, OPC_STORE);
  - funct3 enum (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - `mem_state_t` enum.
- One sub-module, `load_extend`: combinational lane select plus sign/zero extension (inputs `funct3`, addr[1:0], word; output 32-bit result).

## Test plan
- SW, write_address=0x1000_0004, store_data=0xDEADBEEF, busy=0 → `bus_write` pulse in cycle 1, `bus_addr`=0x1000_0004, `bus_sel`=4'b1111, `stall` low in cycle 3.
- LB, read_address=0x0000_0103, bus_rdata=0x80FF_7F01 → `bus_sel`=4'b1000, `load_data`=0xFFFF_FF80, `load_valid`=1 in DONE; LBU on the same inputs → 0x0000_0080.
- SH to 0x0000_0002, store_data=0x0000_1234, busy held high 5 cycles → `bus_wdata`=0x1234_1234, `bus_sel`=4'b1100, `stall` high 8 cycles total.
- `TIMEOUT_CYCLES`=4, busy stuck high → `bus_error` single pulse, `load_valid`=0, FSM back to IDLE.
- `rst` asserted in WAIT → next cycle all outputs 0, state IDLE; an ADD opcode then produces `stall`=0.
- With `MISALIGN_TRAP_EN`, LW at 0x0000_0001 → no `bus_read`, `misaligned`=1 at cycle 1, `stall` low at cycle 1.
